// File: rtl/note_scheduler.sv
`timescale 1ns/1ps
// note_scheduler: paces the falling-note matrix from a chart ROM.
// Emits a one-cycle step_en with the next chart lane mask, drains the
// matrix with ROWS empty rows after the chart ends, then flags completion.
module note_scheduler #(
    parameter logic [23:0] BASE_PERIOD = 24'd2_000_000,
    parameter logic [23:0] DIFF_STEP   = 24'd100_000,
    parameter logic [23:0] MIN_PERIOD  = 24'd200_000,
    parameter int unsigned ROWS        = 16,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic [3:0]    difficulty,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          step_en,
    output logic          note_valid,
    output logic [3:0]    new_note,
    output logic          game_active,
    output logic          chart_done
);

    localparam int unsigned DW = $clog2(ROWS) + 1;
    localparam logic [27:0] BASE_W = {4'd0, BASE_PERIOD};
    localparam logic [27:0] MIN_W  = {4'd0, MIN_PERIOD};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [23:0]     period_q;
    logic [23:0]     div_q;
    logic [DW-1:0]   drain_q;
    logic [AW-1:0]   rom_addr_q;
    logic            hold_end_q;
    logic [3:0]      hold_mask_q;
    logic            cap_q;
    logic            top_q;
    logic            force_end_q;
    logic            step_q;
    logic            valid_q;
    logic [3:0]      note_q;
    logic            active_q;
    logic            done_q;

    logic [27:0]     prod_w;
    logic [27:0]     diff_w;
    logic [23:0]     period_d;
    logic            wrap_d;
    logic            rom_unused;

    // Lane bits [6:4] of the chart word carry no meaning here.
    assign rom_unused = ^rom_data[6:4];

    // Step period for the requested difficulty, floored at MIN_PERIOD.
    always_comb begin
        prod_w = {24'd0, difficulty} * {4'd0, DIFF_STEP};
        diff_w = BASE_W - prod_w;
        if ((prod_w > BASE_W) || (diff_w < MIN_W)) begin
            period_d = MIN_PERIOD;
        end else begin
            period_d = diff_w[23:0];
        end
        wrap_d = (div_q == (period_q - 24'd1));
    end

    // Sequencer FSM with divider, chart prefetch and registered outputs.
    // rom_addr runs one word ahead of the holding register: the ROM samples
    // the pre-edge address, so a capture one edge after each address change
    // picks up the word just emitted's successor. The extra capture after
    // LOAD re-reads word 0 so a restart from DONE never sees a stale word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            period_q    <= '0;
            div_q       <= '0;
            drain_q     <= '0;
            rom_addr_q  <= '0;
            hold_end_q  <= 1'b0;
            hold_mask_q <= '0;
            cap_q       <= 1'b0;
            top_q       <= 1'b0;
            force_end_q <= 1'b0;
            step_q      <= 1'b0;
            valid_q     <= 1'b0;
            note_q      <= '0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            step_q  <= 1'b0;
            valid_q <= 1'b0;
            note_q  <= '0;
            if (stop) begin
                state_q     <= S_IDLE;
                div_q       <= '0;
                drain_q     <= '0;
                rom_addr_q  <= '0;
                hold_end_q  <= 1'b0;
                hold_mask_q <= '0;
                cap_q       <= 1'b0;
                top_q       <= 1'b0;
                force_end_q <= 1'b0;
                active_q    <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                if (cap_q) begin
                    hold_end_q  <= rom_data[7];
                    hold_mask_q <= rom_data[3:0];
                    cap_q       <= 1'b0;
                end
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (state_q == S_IDLE) begin
                            rom_addr_q <= '0;
                        end
                        if (start) begin
                            period_q    <= period_d;
                            rom_addr_q  <= '0;
                            div_q       <= '0;
                            top_q       <= 1'b0;
                            force_end_q <= 1'b0;
                            active_q    <= 1'b1;
                            done_q      <= 1'b0;
                            state_q     <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        hold_end_q  <= rom_data[7];
                        hold_mask_q <= rom_data[3:0];
                        cap_q       <= 1'b1;
                        rom_addr_q  <= AW'(1);
                        div_q       <= '0;
                        state_q     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (!pause) begin
                            if (wrap_d) begin
                                div_q  <= '0;
                                step_q <= 1'b1;
                                if (hold_end_q || force_end_q) begin
                                    drain_q <= DW'(ROWS - 1);
                                    if (ROWS == 1) begin
                                        active_q <= 1'b0;
                                        done_q   <= 1'b1;
                                        state_q  <= S_DONE;
                                    end else begin
                                        state_q  <= S_DRAIN;
                                    end
                                end else begin
                                    valid_q <= 1'b1;
                                    note_q  <= hold_mask_q;
                                    if (top_q) begin
                                        force_end_q <= 1'b1;
                                    end else begin
                                        cap_q <= 1'b1;
                                        if (rom_addr_q == '1) begin
                                            top_q <= 1'b1;
                                        end else begin
                                            rom_addr_q <= rom_addr_q + 1'b1;
                                        end
                                    end
                                end
                            end else begin
                                div_q <= div_q + 24'd1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (!pause) begin
                            if (wrap_d) begin
                                div_q  <= '0;
                                step_q <= 1'b1;
                                if (drain_q <= DW'(1)) begin
                                    drain_q  <= '0;
                                    active_q <= 1'b0;
                                    done_q   <= 1'b1;
                                    state_q  <= S_DONE;
                                end else begin
                                    drain_q <= drain_q - 1'b1;
                                end
                            end else begin
                                div_q <= div_q + 24'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr    = rom_addr_q;
    assign step_en     = step_q;
    assign note_valid  = valid_q;
    assign new_note    = note_q;
    assign game_active = active_q;
    assign chart_done  = done_q;

endmodule
